instr_encoder: RTL and testbench

- Inverse of the decode-stage control unit: accepts decoded operation descriptors (op class, ALU op, data size, register indices, immediate) over a valid/ready handshake.
- Encodes each descriptor into a 32-bit brisc instruction word and buffers it in a small FIFO.
- Streams the buffered words into instruction memory at sequential word addresses.
- Used by the boot/test-load path to build programs in imem and by the verification env as a golden encoder for the decoder.

---
 rtl/instr_encoder_pkg.sv | 70 +++++++
 rtl/instr_encoder_if.sv | 38 +++
 rtl/instr_encoder_sync_fifo.sv | 73 +++++++
 rtl/instr_encoder.sv | 235 +++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared brisc encoding types and constants for the instruction encoder:
//   - alu_ctrl_e / data_size_e : decoded ALU operation and memory access size
//   - enc_op_e                 : descriptor operation class
//   - enc_state_e              : encoder sequencing states
//   - OPCODE_* / FUNCT7_*      : RV32-style major opcodes and funct7 values
//   - immediate range helpers  : signed-fit checks for I/S, B and J immediates
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4
  } alu_ctrl_e;

  typedef enum logic {
    SIZE_B = 1'b0,
    SIZE_W = 1'b1
  } data_size_e;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_R     = 3'd2,
    OP_IMM   = 3'd3,
    OP_BEQ   = 3'd4,
    OP_JUMP  = 3'd5,
    OP_AUIPC = 3'd6,
    OP_END   = 3'd7
  } enc_op_e;

  typedef enum logic [1:0] {
    ENC_IDLE  = 2'd0,
    ENC_RUN   = 2'd1,
    ENC_DRAIN = 2'd2,
    ENC_DONE  = 2'd3
  } enc_state_e;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;
  localparam logic [6:0] OPCODE_R     = 7'b0110011;
  localparam logic [6:0] OPCODE_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_BEQ   = 7'b1100011;
  localparam logic [6:0] OPCODE_JUMP  = 7'b1101111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [6:0] OPCODE_END   = 7'b0001011;

  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;
  localparam logic [6:0] FUNCT7_SUB = 7'b0100000;

  // True when v is representable as a 12-bit signed value (all bits above 10 equal)
  function automatic logic fits_simm12(logic [31:0] v);
    return (v[31:11] == 21'h00_0000) || (v[31:11] == 21'h1F_FFFF);
  endfunction

  // True when v is representable as a 13-bit signed value (branch offset)
  function automatic logic fits_simm13(logic [31:0] v);
    return (v[31:12] == 20'h0_0000) || (v[31:12] == 20'hF_FFFF);
  endfunction

  // True when v is representable as a 21-bit signed value (jump offset)
  function automatic logic fits_simm21(logic [31:0] v);
    return (v[31:20] == 12'h000) || (v[31:20] == 12'hFFF);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Bundles the descriptor request handshake and the imem write handshake.
//   master : descriptor source / imem sink (drives req_*, wr_ready)
//   slave  : the encoder (drives req_ready, wr_valid, wr_addr, wr_data)
// -----------------------------------------------------------------------------
interface instr_encoder_if;
  import instr_encoder_pkg::*;

  logic        req_valid;
  logic        req_ready;
  enc_op_e     req_op;
  alu_ctrl_e   req_alu;
  data_size_e  req_size;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output req_valid, req_op, req_alu, req_size, req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );

  modport slave (
    input  req_valid, req_op, req_alu, req_size, req_rd, req_rs1, req_rs2, req_imm,
    output req_ready,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );

endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered full/empty flags.
//   clk, rst_n        : clock, synchronous active-low reset (empties the FIFO)
//   push, push_data   : write request (ignored while full)
//   pop               : read request (ignored while empty)
//   head              : oldest entry, valid while !empty
//   full, empty       : registered occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nx_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             full_r;
  logic             empty_r;

  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && !empty_r;
  assign head      = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = empty_r;

  // Next occupancy, used to register the flags one cycle ahead
  always_comb begin
    count_nx_s = count_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
  end

  // Storage, pointers and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nx_s;
      full_r  <= (count_nx_s == (AW+1)'(DEPTH));
      empty_r <= (count_nx_s == (AW+1)'(0));
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Encodes decoded operation descriptors into 32-bit brisc instruction words,
// buffers them, and streams them into imem at sequential word addresses.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : one-cycle pulse, begins a program at BASE_ADDR (IDLE/DONE only)
//   bus        : instr_encoder_if.slave - descriptor request and imem write
//   busy       : program in progress (RUN or DRAIN)
//   done       : END word written to imem
//   err        : sticky, an illegal descriptor was accepted and dropped
//   ovf        : sticky, the write index wrapped past IMEM_WORDS
//   checksum   : XOR of every word written since start
//                (present only when INSTR_ENC_CHECKSUM_EN is defined)
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start,
  instr_encoder_if.slave bus,
  output logic  busy,
  output logic  done,
  output logic  err,
`ifdef INSTR_ENC_CHECKSUM_EN
  output logic  ovf,
  output logic [31:0] checksum
`else
  output logic  ovf
`endif
);

  localparam int unsigned IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  localparam logic [1:0] ST_IDLE  = ENC_IDLE;
  localparam logic [1:0] ST_RUN   = ENC_RUN;
  localparam logic [1:0] ST_DRAIN = ENC_DRAIN;
  localparam logic [1:0] ST_DONE  = ENC_DONE;

  logic [1:0]       state_r;
  logic [IDX_W-1:0] wr_idx_r;
  logic             done_r;
  logic             err_r;
  logic             ovf_r;

  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [31:0]      fifo_head_s;
  logic             accept_s;
  logic             push_s;
  logic             wr_fire_s;
  logic             start_ok_s;

  logic [31:0]      enc_word_s;
  logic             enc_legal_s;
  logic [2:0]       funct3_s;
  logic [6:0]       funct7_s;
  logic             alu_ok_s;
  logic [2:0]       ls_funct3_s;
  logic [31:0]      imm_s;

  assign imm_s       = bus.req_imm;
  assign start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign accept_s    = bus.req_valid && bus.req_ready;
  // Illegal descriptors complete the handshake but never reach the FIFO
  assign push_s      = accept_s && enc_legal_s;
  assign wr_fire_s   = bus.wr_valid && bus.wr_ready;

  assign bus.req_ready = (state_r == ST_RUN) && !fifo_full_s;
  assign bus.wr_valid  = !fifo_empty_s;
  assign bus.wr_data   = fifo_head_s;
  assign bus.wr_addr   = BASE_ADDR + 32'(wr_idx_r) * 32'd4;

  assign busy = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign done = done_r;
  assign err  = err_r;
  assign ovf  = ovf_r;

  assign ls_funct3_s = (bus.req_size == SIZE_W) ? 3'b010 : 3'b000;

  // ALU-dependent fields shared by the R and IMM forms
  always_comb begin
    funct3_s = 3'b000;
    funct7_s = 7'b0000000;
    alu_ok_s = 1'b1;
    case (bus.req_alu)
      ALU_ADD: funct3_s = 3'b000;
      ALU_SUB: funct7_s = FUNCT7_SUB;
      ALU_MUL: funct7_s = FUNCT7_MUL;
      ALU_OR:  funct3_s = 3'b110;
      ALU_AND: funct3_s = 3'b111;
      default: alu_ok_s = 1'b0;
    endcase
  end

  // Descriptor to instruction word, plus legality of the descriptor
  always_comb begin
    enc_word_s  = 32'h0000_0000;
    enc_legal_s = 1'b0;
    case (bus.req_op)
      OP_LOAD: begin
        enc_word_s  = {imm_s[11:0], bus.req_rs1, ls_funct3_s, bus.req_rd, OPCODE_LOAD};
        enc_legal_s = fits_simm12(imm_s);
      end
      OP_STORE: begin
        enc_word_s  = {imm_s[11:5], bus.req_rs2, bus.req_rs1, ls_funct3_s, imm_s[4:0], OPCODE_STORE};
        enc_legal_s = fits_simm12(imm_s);
      end
      OP_R: begin
        enc_word_s  = {funct7_s, bus.req_rs2, bus.req_rs1, funct3_s, bus.req_rd, OPCODE_R};
        enc_legal_s = alu_ok_s;
      end
      OP_IMM: begin
        // I-type has no funct7 slot, so SUB and MUL have no immediate form
        enc_word_s  = {imm_s[11:0], bus.req_rs1, funct3_s, bus.req_rd, OPCODE_IMM};
        enc_legal_s = alu_ok_s && (bus.req_alu != ALU_SUB) && (bus.req_alu != ALU_MUL)
                      && fits_simm12(imm_s);
      end
      OP_BEQ: begin
        enc_word_s  = {imm_s[12], imm_s[10:5], bus.req_rs2, bus.req_rs1, 3'b000,
                       imm_s[4:1], imm_s[11], OPCODE_BEQ};
        enc_legal_s = !imm_s[0] && fits_simm13(imm_s);
      end
      OP_JUMP: begin
        enc_word_s  = {imm_s[20], imm_s[10:1], imm_s[11], imm_s[19:12], bus.req_rd, OPCODE_JUMP};
        enc_legal_s = !imm_s[0] && fits_simm21(imm_s);
      end
      OP_AUIPC: begin
        enc_word_s  = {imm_s[31:12], bus.req_rd, OPCODE_AUIPC};
        enc_legal_s = 1'b1;
      end
      OP_END: begin
        enc_word_s  = {25'h000_0000, OPCODE_END};
        enc_legal_s = 1'b1;
      end
      default: begin
        enc_word_s  = 32'h0000_0000;
        enc_legal_s = 1'b0;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (enc_word_s),
    .pop       (wr_fire_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Program sequencing and done flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_ok_s) begin
            state_r <= ST_RUN;
            done_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept_s && (bus.req_op == OP_END)) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // wr_valid mirrors !empty, so an empty FIFO also means no write is pending
          if (fifo_empty_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Write index, wrap detection and illegal-descriptor flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx_r <= '0;
      err_r    <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (start_ok_s) begin
      wr_idx_r <= '0;
      err_r    <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (accept_s && !enc_legal_s) begin
        err_r <= 1'b1;
      end
      if (wr_fire_s) begin
        if (wr_idx_r == IDX_W'(IMEM_WORDS - 1)) begin
          wr_idx_r <= '0;
          ovf_r    <= 1'b1;
        end else begin
          wr_idx_r <= wr_idx_r + IDX_W'(1);
        end
      end
    end
  end

`ifdef INSTR_ENC_CHECKSUM_EN
  logic [31:0] checksum_r;

  assign checksum = checksum_r;

  // Running XOR of every word handed to imem since start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_r <= 32'h0000_0000;
    end else if (start_ok_s) begin
      checksum_r <= 32'h0000_0000;
    end else if (wr_fire_s) begin
      checksum_r <= checksum_r ^ fifo_head_s;
    end else begin
      checksum_r <= checksum_r;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder: directed program fragments with known
// encodings, illegal descriptors, FIFO backpressure, randomized descriptors
// with random imem readiness, index wrap, and reset during drain. Expected
// words/addresses come from an arithmetic reference model of the encoding rules.
// -----------------------------------------------------------------------------
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          IMEM = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err, ovf;
`ifdef INSTR_ENC_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  instr_encoder_if bus();

  logic ready_mode = 1'b0;
  logic ready_val  = 1'b0;
  logic rnd_bit    = 1'b0;
  assign bus.wr_ready = ready_mode ? rnd_bit : ready_val;

  instr_encoder #(
    .FIFO_DEPTH (4),
    .BASE_ADDR  (BASE),
    .IMEM_WORDS (IMEM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
`ifdef INSTR_ENC_CHECKSUM_EN
    .ovf      (ovf),
    .checksum (checksum)
`else
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          exp_idx = 0;
  logic        exp_err = 1'b0;
  logic        exp_ovf = 1'b0;
  logic [31:0] exp_chk = 32'h0;
  int          n_acc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference encoding from the instruction format rules; returns legality
  function automatic bit model_enc(input int op, input int alu, input int size,
                                   input int rd, input int rs1, input int rs2,
                                   input int imm, output logic [31:0] w);
    logic [31:0] u, r_d, r_s1, r_s2;
    int f3, f7, ls3;
    u    = imm;
    r_d  = rd;
    r_s1 = rs1;
    r_s2 = rs2;
    w    = 32'h0;
    f3   = (alu == 4) ? 7 : (alu == 3) ? 6 : 0;
    f7   = (alu == 1) ? 32 : (alu == 2) ? 1 : 0;
    ls3  = (size == 1) ? 2 : 0;
    case (op)
      OP_LOAD: begin
        if (imm < -2048 || imm > 2047) return 1'b0;
        w = ((u & 32'hFFF) << 20) | (r_s1 << 15) | (ls3 << 12) | (r_d << 7) | 32'h03;
        return 1'b1;
      end
      OP_STORE: begin
        if (imm < -2048 || imm > 2047) return 1'b0;
        w = (((u >> 5) & 32'h7F) << 25) | (r_s2 << 20) | (r_s1 << 15) | (ls3 << 12)
            | ((u & 32'h1F) << 7) | 32'h23;
        return 1'b1;
      end
      OP_R: begin
        if (alu > 4) return 1'b0;
        w = (f7 << 25) | (r_s2 << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | 32'h33;
        return 1'b1;
      end
      OP_IMM: begin
        if (alu > 4 || alu == 1 || alu == 2) return 1'b0;
        if (imm < -2048 || imm > 2047) return 1'b0;
        w = ((u & 32'hFFF) << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | 32'h13;
        return 1'b1;
      end
      OP_BEQ: begin
        if (imm % 2 != 0 || imm < -4096 || imm > 4094) return 1'b0;
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (r_s2 << 20) | (r_s1 << 15)
            | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
        return 1'b1;
      end
      OP_JUMP: begin
        if (imm % 2 != 0 || imm < -1048576 || imm > 1048574) return 1'b0;
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
            | (((u >> 12) & 32'hFF) << 12) | (r_d << 7) | 32'h6F;
        return 1'b1;
      end
      OP_AUIPC: begin
        w = (u & 32'hFFFF_F000) | (r_d << 7) | 32'h17;
        return 1'b1;
      end
      default: begin
        w = 32'h0000_000B;
        return 1'b1;
      end
    endcase
  endfunction

  // Write-port monitor: every presented word must match the model's next word
  always @(negedge clk) begin
    if (rst_n && bus.wr_valid === 1'b1) begin
      check_val("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check_val("wr_addr", bus.wr_addr, exp_q[0][63:32]);
        check_val("wr_data", bus.wr_data, exp_q[0][31:0]);
        if (bus.wr_ready) begin
          obs_q.push_back({bus.wr_addr, bus.wr_data});
          exp_chk = exp_chk ^ exp_q[0][31:0];
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Present one descriptor, wait (bounded) for acceptance, update the model
  task automatic send(input int op, input int alu, input int size, input int rd,
                      input int rs1, input int rs2, input int imm);
    logic [31:0] w;
    bit ok, got;
    bus.req_op    = enc_op_e'(3'(op));
    bus.req_alu   = alu_ctrl_e'(3'(alu));
    bus.req_size  = data_size_e'(1'(size));
    bus.req_rd    = 5'(rd);
    bus.req_rs1   = 5'(rs1);
    bus.req_rs2   = 5'(rs2);
    bus.req_imm   = 32'(imm);
    bus.req_valid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check_val("req_accept", 32'(got), 32'd1);
    if (got) begin
      n_acc++;
      ok = model_enc(op, alu, size, rd, rs1, rs2, imm, w);
      if (ok) begin
        exp_q.push_back({BASE + 32'(exp_idx) * 32'd4, w});
        exp_idx++;
        if (exp_idx == IMEM) begin
          exp_idx = 0;
          exp_ovf = 1'b1;
        end
      end else begin
        exp_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_start();
    exp_idx = 0;
    exp_err = 1'b0;
    exp_ovf = 1'b0;
    exp_chk = 32'h0;
    obs_q.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_val("start_busy", 32'(busy), 32'd1);
    check_val("start_done", 32'(done), 32'd0);
    check_val("start_err", 32'(err), 32'd0);
    check_val("start_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check_val({tag, "_done"}, 32'(seen), 32'd1);
    check_val({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_err"}, 32'(err), 32'(exp_err));
    check_val({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`ifdef INSTR_ENC_CHECKSUM_EN
    check_val({tag, "_checksum"}, checksum, exp_chk);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic check_obs(input string tag, input int i, input logic [31:0] addr,
                           input logic [31:0] data);
    logic [63:0] e;
    e = 64'h0;
    if (i < obs_q.size()) e = obs_q[i];
    check_val({tag, "_addr"}, e[63:32], addr);
    check_val({tag, "_data"}, e[31:0], data);
  endtask

  function automatic int rand_imm();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 4095)) - 2048;
      1:       return int'($urandom_range(0, 12000)) - 6000;
      2:       return int'($urandom_range(0, 2200000)) - 1100000;
      default: return int'($urandom);
    endcase
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = OP_END;
    bus.req_alu   = ALU_ADD;
    bus.req_size  = SIZE_B;
    bus.req_rd    = 5'd0;
    bus.req_rs1   = 5'd0;
    bus.req_rs2   = 5'd0;
    bus.req_imm   = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_val("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    check_val("rst_wr_addr", bus.wr_addr, BASE);
    check_val("rst_wr_data", bus.wr_data, 32'h0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    ready_val = 1'b1;
    @(posedge clk);
    #1;

    // Minimal program
    do_start();
    send(OP_IMM, ALU_ADD, 0, 1, 0, 0, 5);
    send(OP_END, 0, 0, 0, 0, 0, 0);
    wait_done("prog1");
    check_obs("p1w0", 0, 32'h0000_1000, 32'h0050_0093);
    check_obs("p1w1", 1, 32'h0000_1004, 32'h0000_000B);

    // Known encodings across formats
    do_start();
    send(OP_R, ALU_ADD, 0, 3, 1, 2, 0);
    send(OP_R, ALU_SUB, 0, 3, 1, 2, 0);
    send(OP_R, ALU_MUL, 0, 3, 1, 2, 0);
    send(OP_LOAD, ALU_ADD, 1, 5, 2, 0, 8);
    send(OP_STORE, ALU_ADD, 1, 0, 2, 5, 12);
    send(OP_BEQ, ALU_ADD, 0, 0, 1, 2, 8);
    send(OP_JUMP, ALU_ADD, 0, 1, 0, 0, 16);
    send(OP_END, 0, 0, 0, 0, 0, 0);
    wait_done("prog2");
    check_obs("r_add", 0, 32'h0000_1000, 32'h0020_81B3);
    check_obs("r_sub", 1, 32'h0000_1004, 32'h4020_81B3);
    check_obs("r_mul", 2, 32'h0000_1008, 32'h0220_81B3);
    check_obs("ld_w", 3, 32'h0000_100C, 32'h0081_2283);
    check_obs("st_w", 4, 32'h0000_1010, 32'h0051_2623);
    check_obs("beq", 5, 32'h0000_1014, 32'h0020_8463);
    check_obs("jal", 6, 32'h0000_1018, 32'h0100_00EF);

    // Illegal descriptors are accepted but dropped
    do_start();
    send(OP_IMM, ALU_MUL, 0, 1, 0, 0, 5);
    send(OP_IMM, ALU_ADD, 0, 1, 0, 0, 4096);
    send(OP_BEQ, ALU_ADD, 0, 0, 1, 2, 3);
    repeat (3) @(negedge clk);
    check_val("illegal_err", 32'(err), 32'd1);
    check_val("illegal_no_write", 32'(bus.wr_valid), 32'd0);
    @(posedge clk);
    #1;
    send(OP_IMM, ALU_ADD, 0, 1, 0, 0, 5);
    send(OP_END, 0, 0, 0, 0, 0, 0);
    wait_done("illegal");
    check_obs("after_illegal", 0, 32'h0000_1000, 32'h0050_0093);

    // Backpressure: imem stalls while six descriptors are offered
    do_start();
    ready_val = 1'b0;
    n_acc     = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(OP_IMM, ALU_OR, 0, i + 1, i, 0, 100 + i);
        end
      end
      begin
        repeat (10) @(negedge clk);
        check_val("bp_accepts", 32'(n_acc), 32'd4);
        check_val("bp_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        ready_val = 1'b1;
      end
    join
    send(OP_END, 0, 0, 0, 0, 0, 0);
    wait_done("backpressure");
    check_val("bp_words", 32'(obs_q.size()), 32'd7);

    // Randomized descriptors with random imem readiness
    do_start();
    ready_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(int'($urandom_range(0, 6)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           rand_imm());
    end
    send(OP_END, 0, 0, 0, 0, 0, 0);
    wait_done("random");
    ready_mode = 1'b0;
    ready_val  = 1'b1;

    // Write index wraps past the end of imem
    do_start();
    for (int i = 0; i < IMEM + 6; i++) begin
      send(OP_IMM, ALU_ADD, 0, i % 32, 0, 0, i % 2000);
    end
    send(OP_END, 0, 0, 0, 0, 0, 0);
    wait_done("wrap");
    check_val("wrap_last_addr", obs_q[obs_q.size() - 1][63:32], BASE + 32'd4 * 32'd6);

    // Reset while draining discards the buffered words
    do_start();
    ready_val = 1'b0;
    send(OP_R, ALU_AND, 0, 7, 8, 9, 0);
    send(OP_R, ALU_OR, 0, 7, 8, 9, 0);
    send(OP_R, ALU_ADD, 0, 7, 8, 9, 0);
    send(OP_END, 0, 0, 0, 0, 0, 0);
    ready_val = 1'b1;
    @(posedge clk);
    #1;
    ready_val = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("mid_rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_wr_addr", bus.wr_addr, BASE);
    check_val("mid_rst_err", 32'(err), 32'd0);
    check_val("mid_rst_done", 32'(done), 32'd0);
`ifdef INSTR_ENC_CHECKSUM_EN
    check_val("mid_rst_checksum", checksum, 32'h0);
`endif
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("post_rst_wr_valid", 32'(bus.wr_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
